// File: rtl/nn_mlp_engine.sv
// nn_mlp_engine: fixed-point 2-layer dense network (input -> hidden ReLU -> scores -> argmax)
// evaluated on a single sequential MAC. Pixels, weights and biases arrive through a load port.
module nn_mlp_engine #(
    parameter int N_IN  = 784,
    parameter int N_HID = 128,
    parameter int N_OUT = 10,
    parameter int WW    = 16,
    parameter int FRAC  = 8,
    parameter int HW    = 16,
    parameter int ACCW  = 48,
    parameter int AW    = 17,
    parameter int OW    = 4
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic                   ld_we,
    input  logic [2:0]             ld_sel,
    input  logic [AW-1:0]          ld_addr,
    input  logic [WW-1:0]          ld_data,
    output logic                   ld_err,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [OW-1:0]          digit,
    output logic signed [ACCW-1:0] score
);

    // Pixels are Q0.8, so layer-1 products carry 8 extra fractional bits.
    localparam int PIX_FRAC = 8;

    localparam int IMG_IW = $clog2(N_IN);
    localparam int W1_IW  = $clog2(N_IN * N_HID);
    localparam int HID_IW = $clog2(N_HID);
    localparam int W2_IW  = $clog2(N_HID * N_OUT);
    localparam int OUT_IW = $clog2(N_OUT);
    localparam int CW0    = (IMG_IW > HID_IW) ? IMG_IW : HID_IW;
    localparam int CW     = (CW0 > OUT_IW) ? CW0 : OUT_IW;

    // Target depths, one bit wider than the address so a full 2^AW depth still compares.
    localparam logic [AW:0] D_IMG = (AW+1)'(N_IN);
    localparam logic [AW:0] D_W1  = (AW+1)'(N_IN * N_HID);
    localparam logic [AW:0] D_B1  = (AW+1)'(N_HID);
    localparam logic [AW:0] D_W2  = (AW+1)'(N_HID * N_OUT);
    localparam logic [AW:0] D_B2  = (AW+1)'(N_OUT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_L1_MAC  = 3'd1;
    localparam logic [2:0] S_L1_ACT  = 3'd2;
    localparam logic [2:0] S_L2_MAC  = 3'd3;
    localparam logic [2:0] S_L2_BIAS = 3'd4;
    localparam logic [2:0] S_ARGMAX  = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    // Storage: plain register arrays, read combinationally, never cleared by reset.
    logic [7:0]             r_img [N_IN];
    logic signed [WW-1:0]   r_w1  [N_IN*N_HID];
    logic signed [WW-1:0]   r_b1  [N_HID];
    logic signed [WW-1:0]   r_w2  [N_HID*N_OUT];
    logic signed [WW-1:0]   r_b2  [N_OUT];
    logic [HW-1:0]          r_hid [N_HID];
    logic signed [ACCW-1:0] r_out [N_OUT];

    // Control and result registers.
    logic [2:0]             r_state;
    logic [CW-1:0]          r_j;
    logic [CW-1:0]          r_k;
    logic signed [ACCW-1:0] r_acc;
    logic signed [ACCW-1:0] r_max;
    logic [OW-1:0]          r_idx;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ld_err;
    logic [OW-1:0]          r_digit;
    logic signed [ACCW-1:0] r_score;

    // Datapath wires.
    logic                   w_addr_ok;
    logic                   w_ld_ok;
    logic [7:0]             w_img;
    logic signed [WW-1:0]   w_w1;
    logic signed [WW-1:0]   w_w2;
    logic [HW-1:0]          w_hid;
    logic signed [WW+8:0]   w_prod1;
    logic signed [WW+HW:0]  w_prod2;
    logic signed [ACCW-1:0] w_t;
    logic signed [ACCW-1:0] w_t_sh;
    logic [HW-1:0]          w_hid_new;
    logic signed [ACCW-1:0] w_outv;
    logic signed [ACCW-1:0] w_cand;

    // Load-port acceptance: idle engine, valid target, address inside the target.
    always_comb begin
        w_addr_ok = 1'b0;
        case (ld_sel)
            3'd0:    w_addr_ok = {1'b0, ld_addr} < D_IMG;
            3'd1:    w_addr_ok = {1'b0, ld_addr} < D_W1;
            3'd2:    w_addr_ok = {1'b0, ld_addr} < D_B1;
            3'd3:    w_addr_ok = {1'b0, ld_addr} < D_W2;
            3'd4:    w_addr_ok = {1'b0, ld_addr} < D_B2;
            default: w_addr_ok = 1'b0;
        endcase
        w_ld_ok = ld_we && !r_busy && (r_state != S_DONE) && w_addr_ok;
    end

    // Memory writes from the load port.
    always_ff @(posedge CLK) begin
        if (w_ld_ok) begin
            case (ld_sel)
                3'd0:    r_img[ld_addr[IMG_IW-1:0]] <= ld_data[7:0];
                3'd1:    r_w1[ld_addr[W1_IW-1:0]]   <= ld_data;
                3'd2:    r_b1[ld_addr[HID_IW-1:0]]  <= ld_data;
                3'd3:    r_w2[ld_addr[W2_IW-1:0]]   <= ld_data;
                3'd4:    r_b2[ld_addr[OUT_IW-1:0]]  <= ld_data;
                default: ;
            endcase
        end
    end

    // MAC operands, bias alignment and requantisation of the hidden activation.
    always_comb begin
        w_img   = r_img[r_k[IMG_IW-1:0]];
        w_w1    = r_w1[W1_IW'(r_k * N_HID + r_j)];
        w_hid   = r_hid[r_k[HID_IW-1:0]];
        w_w2    = r_w2[W2_IW'(r_k * N_OUT + r_j)];
        // Zero-extend the unsigned operand so the product stays a signed multiply.
        w_prod1 = $signed({1'b0, w_img}) * w_w1;
        w_prod2 = $signed({1'b0, w_hid}) * w_w2;
        // Q.(8+FRAC) sum plus Q.FRAC bias, then drop the pixel fraction back to Q.FRAC.
        w_t     = r_acc + (ACCW'(r_b1[r_j[HID_IW-1:0]]) <<< PIX_FRAC);
        w_t_sh  = w_t >>> PIX_FRAC;
        if (w_t[ACCW-1])
            w_hid_new = '0;
        else if (|w_t_sh[ACCW-1:HW])
            w_hid_new = '1;
        else
            w_hid_new = w_t_sh[HW-1:0];
        w_outv  = r_acc + (ACCW'(r_b2[r_j[OUT_IW-1:0]]) <<< FRAC);
        w_cand  = r_out[r_k[OUT_IW-1:0]];
    end

    // Hidden activations and output scores are written at the end of each neuron.
    always_ff @(posedge CLK) begin
        if (r_state == S_L1_ACT)
            r_hid[r_j[HID_IW-1:0]] <= w_hid_new;
        if (r_state == S_L2_BIAS)
            r_out[r_j[OUT_IW-1:0]] <= w_outv;
    end

    // Sequencer: j walks neurons, k walks the MAC inputs (and classes during argmax).
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_j      <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_max    <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ld_err <= 1'b0;
            r_digit  <= '0;
            r_score  <= '0;
        end else begin
            r_done   <= 1'b0;
            r_ld_err <= ld_we && !w_ld_ok;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_L1_MAC;
                        r_busy  <= 1'b1;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_acc   <= '0;
                    end
                end
                S_L1_MAC: begin
                    r_acc <= r_acc + ACCW'(w_prod1);
                    if (r_k == CW'(N_IN - 1)) begin
                        r_k     <= '0;
                        r_state <= S_L1_ACT;
                    end else begin
                        r_k <= r_k + CW'(1);
                    end
                end
                S_L1_ACT: begin
                    r_acc <= '0;
                    if (r_j == CW'(N_HID - 1)) begin
                        r_j     <= '0;
                        r_state <= S_L2_MAC;
                    end else begin
                        r_j     <= r_j + CW'(1);
                        r_state <= S_L1_MAC;
                    end
                end
                S_L2_MAC: begin
                    r_acc <= r_acc + ACCW'(w_prod2);
                    if (r_k == CW'(N_HID - 1)) begin
                        r_k     <= '0;
                        r_state <= S_L2_BIAS;
                    end else begin
                        r_k <= r_k + CW'(1);
                    end
                end
                S_L2_BIAS: begin
                    r_acc <= '0;
                    if (r_j == CW'(N_OUT - 1)) begin
                        r_j     <= '0;
                        r_k     <= '0;
                        r_state <= S_ARGMAX;
                    end else begin
                        r_j     <= r_j + CW'(1);
                        r_state <= S_L2_MAC;
                    end
                end
                S_ARGMAX: begin
                    // Strictly greater keeps the lowest index on ties.
                    if (r_k == '0 || w_cand > r_max) begin
                        r_max <= w_cand;
                        r_idx <= OW'(r_k);
                    end
                    if (r_k == CW'(N_OUT - 1)) begin
                        r_k     <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k + CW'(1);
                    end
                end
                S_DONE: begin
                    r_digit <= r_idx;
                    r_score <= r_max;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ld_err = r_ld_err;
    assign busy   = r_busy;
    assign done   = r_done;
    assign digit  = r_digit;
    assign score  = r_score;

endmodule

// File: tb/tb_nn_mlp_engine.sv
// Bench for nn_mlp_engine: two instances (HW=16 and HW=8) share all stimulus; results are
// compared against a plain-arithmetic model of the network and against hand-derived constants.
module tb_nn_mlp_engine;

    localparam int N_IN = 4, N_HID = 3, N_OUT = 2;
    localparam int WW = 16, FRAC = 8, ACCW = 48, AW = 17, OW = 4;

    logic            CLK = 1'b0;
    logic            rst_n = 1'b0;
    logic            ld_we = 1'b0;
    logic [2:0]      ld_sel = '0;
    logic [AW-1:0]   ld_addr = '0;
    logic [WW-1:0]   ld_data = '0;
    logic            start = 1'b0;

    logic            ld_err_a, busy_a, done_a, ld_err_b, busy_b, done_b;
    logic [OW-1:0]   digit_a, digit_b;
    logic [ACCW-1:0] score_a, score_b;

    int checks = 0;
    int failures = 0;

    // Network contents as the bench believes they are loaded.
    int img [N_IN];
    int w1  [N_IN*N_HID];
    int b1  [N_HID];
    int w2  [N_HID*N_OUT];
    int b2  [N_OUT];

    // Results captured at the first done of a run.
    int     g_lat, g_ndone, g_busy_err, g_dig_a, g_dig_b, g_done_b;
    longint g_sc_a, g_sc_b;

    always #5 CLK = ~CLK;

    nn_mlp_engine #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .WW(WW), .FRAC(FRAC),
                    .HW(16), .ACCW(ACCW), .AW(AW), .OW(OW)) u_a (
        .CLK(CLK), .rst_n(rst_n), .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_err(ld_err_a), .start(start), .busy(busy_a), .done(done_a),
        .digit(digit_a), .score(score_a));

    nn_mlp_engine #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .WW(WW), .FRAC(FRAC),
                    .HW(8), .ACCW(ACCW), .AW(AW), .OW(OW)) u_b (
        .CLK(CLK), .rst_n(rst_n), .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_err(ld_err_b), .start(start), .busy(busy_b), .done(done_b),
        .digit(digit_b), .score(score_b));

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One load-port write; returns the ld_err seen the following cycle.
    task automatic wr(input int sel, input int addr, input int val, output logic err);
        ld_we = 1'b1; ld_sel = 3'(sel); ld_addr = AW'(addr); ld_data = WW'(val);
        @(posedge CLK); #1;
        ld_we = 1'b0;
        err = ld_err_a | ld_err_b;
    endtask

    task automatic load_all(input string tag);
        logic e;
        logic any = 1'b0;
        for (int i = 0; i < N_IN; i++)        begin wr(0, i, img[i], e); any |= e; end
        for (int i = 0; i < N_IN*N_HID; i++)  begin wr(1, i, w1[i], e);  any |= e; end
        for (int i = 0; i < N_HID; i++)       begin wr(2, i, b1[i], e);  any |= e; end
        for (int i = 0; i < N_HID*N_OUT; i++) begin wr(3, i, w2[i], e);  any |= e; end
        for (int i = 0; i < N_OUT; i++)       begin wr(4, i, b2[i], e);  any |= e; end
        chk({tag, "_load_ok"}, longint'(any), 0);
    endtask

    task automatic set_basic();
        for (int i = 0; i < N_IN; i++) img[i] = 128;
        for (int i = 0; i < N_IN*N_HID; i++) w1[i] = 256;
        for (int i = 0; i < N_HID; i++) b1[i] = 0;
        for (int k = 0; k < N_HID; k++) begin w2[k*N_OUT] = 256; w2[k*N_OUT+1] = -256; end
        for (int i = 0; i < N_OUT; i++) b2[i] = 0;
    endtask

    // Reference network: fixed-point rules written as ordinary integer arithmetic.
    task automatic model(input int hw, output int dig, output longint sc);
        longint h [N_HID];
        longint o [N_OUT];
        longint t;
        for (int j = 0; j < N_HID; j++) begin
            t = longint'(b1[j]) * 256;
            for (int k = 0; k < N_IN; k++) t += longint'(img[k]) * w1[k*N_HID+j];
            if (t < 0) h[j] = 0;
            else begin
                h[j] = t / 256;
                if (h[j] > (longint'(1) << hw) - 1) h[j] = (longint'(1) << hw) - 1;
            end
        end
        for (int j = 0; j < N_OUT; j++) begin
            o[j] = longint'(b2[j]) * 256;
            for (int k = 0; k < N_HID; k++) o[j] += h[k] * w2[k*N_OUT+j];
        end
        dig = 0; sc = o[0];
        for (int i = 1; i < N_OUT; i++) if (o[i] > sc) begin sc = o[i]; dig = i; end
    endtask

    // One inference: start held `hold` cycles, optional W1[0] write at cycle `bw`,
    // fixed 120-cycle observation window counting done pulses.
    task automatic run(input int hold, input int bw);
        g_lat = -1; g_ndone = 0; g_busy_err = -1; g_done_b = 0;
        start = 1'b1;
        @(posedge CLK); #1;
        if (hold <= 1) start = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            @(posedge CLK); #1;
            if (c + 1 >= hold) start = 1'b0;
            if (c == bw + 1) begin ld_we = 1'b0; g_busy_err = int'(ld_err_a); end
            if (c == bw) begin ld_we = 1'b1; ld_sel = 3'd1; ld_addr = '0; ld_data = WW'(-1000); end
            if (done_a) begin
                g_ndone++;
                if (g_lat < 0) begin
                    g_lat = c;
                    g_dig_a = int'(digit_a); g_sc_a = $signed(score_a);
                    g_dig_b = int'(digit_b); g_sc_b = $signed(score_b);
                    g_done_b = int'(done_b);
                end
            end
        end
    endtask

    initial begin
        int     md, nd;
        longint ms;
        logic   e;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ld_err", longint'(ld_err_a), 0);
        chk("rst_busy", longint'(busy_a), 0);
        chk("rst_done", longint'(done_a), 0);
        chk("rst_digit", longint'(digit_a), 0);
        chk("rst_score", $signed(score_a), 0);
        rst_n = 1'b1;
        @(posedge CLK); #1;

        // Basic run
        set_basic();
        load_all("basic");
        run(1, -1);
        chk("basic_latency", g_lat, 26);
        chk("basic_ndone", g_ndone, 1);
        chk("basic_digit", g_dig_a, 0);
        chk("basic_score", g_sc_a, 393216);
        chk("basic_busy_after", longint'(busy_a), 0);
        model(8, md, ms);
        chk("basic_b_done", g_done_b, 1);
        chk("basic_b_score", g_sc_b, ms);

        // start held for three cycles
        run(3, -1);
        chk("hold_ndone", g_ndone, 1);
        chk("hold_score", g_sc_a, 393216);

        // Write while busy is rejected and leaves memory intact
        run(1, 5);
        chk("busy_ld_err", g_busy_err, 1);
        chk("busy_mem_kept", g_sc_a, 393216);

        // Invalid target and out-of-range addresses
        wr(6, 0, 0, e);   chk("sel6_ld_err", longint'(e), 1);
        wr(1, 12, 0, e);  chk("w1_addr12_ld_err", longint'(e), 1);
        wr(4, 2, 0, e);   chk("b2_addr2_ld_err", longint'(e), 1);
        wr(1, 11, 256, e); chk("w1_addr11_ok", longint'(e), 0);

        // ReLU clamps all hidden to zero; scores are the biases
        for (int i = 0; i < N_IN*N_HID; i++) w1[i] = -256;
        b2[0] = -5; b2[1] = 7;
        load_all("relu");
        run(1, -1);
        chk("relu_digit", g_dig_a, 1);
        chk("relu_score", g_sc_a, 1792);
        model(8, md, ms);
        chk("relu_b_score", g_sc_b, ms);

        // Reset in the middle of a run, then rerun the basic network
        set_basic();
        load_all("rstmid");
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        rst_n = 1'b0;
        #2;
        chk("abort_busy", longint'(busy_a), 0);
        chk("abort_digit", longint'(digit_a), 0);
        chk("abort_score", $signed(score_a), 0);
        nd = 0;
        repeat (2) begin @(posedge CLK); #1; nd += int'(done_a); end
        rst_n = 1'b1;
        repeat (40) begin @(posedge CLK); #1; nd += int'(done_a); end
        chk("abort_no_done", nd, 0);
        run(1, -1);
        chk("rerun_digit", g_dig_a, 0);
        chk("rerun_score", g_sc_a, 393216);

        // Tie keeps the lowest index
        for (int i = 0; i < N_HID*N_OUT; i++) w2[i] = 0;
        b2[0] = 3; b2[1] = 3;
        load_all("tie");
        run(1, -1);
        chk("tie_digit", g_dig_a, 0);
        chk("tie_score", g_sc_a, 768);

        // Saturation of the hidden activation
        for (int i = 0; i < N_IN; i++) img[i] = 255;
        for (int i = 0; i < N_IN*N_HID; i++) w1[i] = 32767;
        for (int i = 0; i < N_HID; i++) b1[i] = 0;
        for (int k = 0; k < N_HID; k++) begin w2[k*N_OUT] = 256; w2[k*N_OUT+1] = 0; end
        b2[0] = 0; b2[1] = 0;
        load_all("sat");
        run(1, -1);
        chk("sat_b_digit", g_dig_b, 0);
        chk("sat_b_score", g_sc_b, 195840);
        chk("sat_a_score", g_sc_a, 50330880);

        // Randomised networks against the model
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < N_IN; i++) img[i] = int'($urandom_range(0, 255));
            for (int i = 0; i < N_IN*N_HID; i++) w1[i] = int'($urandom_range(0, 2047)) - 1024;
            for (int i = 0; i < N_HID; i++) b1[i] = int'($urandom_range(0, 4000)) - 2000;
            for (int i = 0; i < N_HID*N_OUT; i++) w2[i] = int'($urandom_range(0, 2047)) - 1024;
            for (int i = 0; i < N_OUT; i++) b2[i] = int'($urandom_range(0, 1000)) - 500;
            load_all("rand");
            run(1, -1);
            chk("rand_latency", g_lat, 26);
            model(16, md, ms);
            chk("rand_a_digit", g_dig_a, md);
            chk("rand_a_score", g_sc_a, ms);
            model(8, md, ms);
            chk("rand_b_digit", g_dig_b, md);
            chk("rand_b_score", g_sc_b, ms);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
